// File: rtl/pdu_dma_reader_if.sv
// ---------------------------------------------------------------------------
// pdu_dma_reader_if
//
// Groups the signals of the PDU DMA reader's three interfaces:
//   command : dma_start, dma_size, dma_base_addr, dma_queue  (to reader)
//             dma_done                                       (from reader)
//   read    : rd_addr, rd_en                                 (from reader)
//             rd_valid, rd_data (fixed 2-cycle latency)      (to reader)
//   stream  : out_data, out_valid, out_sop, out_eop,
//             out_queue                                      (from reader)
//             out_ready                                      (to reader)
//
// Modports: master = the reader itself, slave = its environment
// (ring buffer, command source and the PCIe DMA write path).
// ---------------------------------------------------------------------------
interface pdu_dma_reader_if #(
    parameter int PDU_AWIDTH    = 9,
    parameter int APP_IDX_WIDTH = 4,
    parameter int DATA_WIDTH    = 512
) ();

    // command
    logic                     dma_start;
    logic [PDU_AWIDTH-1:0]    dma_size;
    logic [PDU_AWIDTH-1:0]    dma_base_addr;
    logic [APP_IDX_WIDTH-1:0] dma_queue;
    logic                     dma_done;

    // ring buffer read port
    logic [PDU_AWIDTH-1:0]    rd_addr;
    logic                     rd_en;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rd_data;

    // output flit stream
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sop;
    logic                     out_eop;
    logic [APP_IDX_WIDTH-1:0] out_queue;

    modport master (
        input  dma_start, dma_size, dma_base_addr, dma_queue,
        output dma_done,
        output rd_addr, rd_en,
        input  rd_valid, rd_data,
        output out_data, out_valid, out_sop, out_eop, out_queue,
        input  out_ready
    );

    modport slave (
        output dma_start, dma_size, dma_base_addr, dma_queue,
        input  dma_done,
        input  rd_addr, rd_en,
        output rd_valid, rd_data,
        input  out_data, out_valid, out_sop, out_eop, out_queue,
        output out_ready
    );

endinterface

// File: rtl/pdu_dma_reader.sv
// ---------------------------------------------------------------------------
// pdu_dma_reader
//
// Takes one per-packet DMA command from the PDU ring buffer, reads the
// packet's flits out of the ring (fixed 2-cycle read latency) and streams
// them on a valid/ready port tagged with sop/eop/queue id. A small output
// FIFO guarded by a credit count (reads in flight + entries queued) absorbs
// the read latency so downstream backpressure never loses a flit. dma_done
// pulses one cycle after the last flit is handed off (or one cycle after a
// zero-length command), letting the ring buffer advance.
//
// Ports:
//   clk, rst      sole clock; synchronous active-high reset
//   bus (master)  command / ring read / output stream, see pdu_dma_reader_if
//   busy          high whenever a packet is in progress
//
// Optional build macro PDU_DMA_READER_STATS_EN adds 32-bit wrapping
// counters stat_pkts (dma_done pulses), stat_flits (output handshakes) and
// stat_stall (cycles with out_valid && !out_ready).
// ---------------------------------------------------------------------------
module pdu_dma_reader #(
    parameter int PDU_DEPTH     = 512,
    parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
    parameter int APP_IDX_WIDTH = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    pdu_dma_reader_if.master bus,
    output logic             busy
`ifdef PDU_DMA_READER_STATS_EN
    ,
    output logic [31:0]      stat_pkts,
    output logic [31:0]      stat_flits,
    output logic [31:0]      stat_stall
`endif
);

    localparam int DATA_W = 512;
    // packet counters are one bit wider than an address so that a packet
    // spanning the whole ring never overflows them
    localparam int CW     = PDU_AWIDTH + 1;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int FCW    = FAW + 1;
    localparam int SUMW   = FCW + 1;

    localparam logic [SUMW-1:0] CREDITS  = SUMW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   RING_END = CW'(PDU_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    // latched command
    logic [PDU_AWIDTH-1:0]    base_q;
    logic [CW-1:0]            size_q;
    logic [APP_IDX_WIDTH-1:0] queue_q;

    // progress counters
    logic [CW-1:0]            issued_q;
    logic [CW-1:0]            accepted_q;
    logic [FCW-1:0]           inflight_q;

    // output FIFO
    logic [DATA_W-1:0]        fifo_data  [FIFO_DEPTH];
    logic                     fifo_sop   [FIFO_DEPTH];
    logic                     fifo_eop   [FIFO_DEPTH];
    logic [APP_IDX_WIDTH-1:0] fifo_queue [FIFO_DEPTH];
    logic [FAW-1:0]           wr_ptr_q;
    logic [FAW-1:0]           rd_ptr_q;
    logic [FCW-1:0]           fifo_count_q;

    logic                     done_q;

    // combinational helpers
    logic [SUMW-1:0]          credit_used;
    logic [CW-1:0]            addr_sum;
    logic [PDU_AWIDTH-1:0]    rd_addr_c;
    logic                     rd_en_c;
    logic                     rd_accept;
    logic                     flit_sop;
    logic                     flit_eop;
    logic                     out_valid_c;
    logic                     out_fire;
    logic                     head_eop;
    logic                     start_pkt;
    logic                     zero_done;
    logic                     pkt_done;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    always_comb begin
        // every issued read owns either an in-flight slot or a FIFO entry
        // until it is handed downstream, so this sum never exceeds the
        // FIFO depth and a returning flit always has room
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};

        // wrap at the end of the ring (same as modulo 2^PDU_AWIDTH for a
        // power-of-two ring)
        addr_sum  = {1'b0, base_q} + {1'b0, issued_q[PDU_AWIDTH-1:0]};
        rd_addr_c = (addr_sum >= RING_END) ? PDU_AWIDTH'(addr_sum - RING_END)
                                           : addr_sum[PDU_AWIDTH-1:0];

        // with nothing outstanding a returning flit can only be left over
        // from before a reset; drop it
        rd_accept = bus.rd_valid && (inflight_q != '0);
        flit_sop  = (accepted_q == '0);
        flit_eop  = (accepted_q == size_q - CW'(1));

        out_valid_c = (fifo_count_q != '0);
        out_fire    = out_valid_c && bus.out_ready;
        head_eop    = fifo_eop[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_en_c   = 1'b0;
        start_pkt = 1'b0;
        zero_done = 1'b0;
        pkt_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.dma_start) begin
                    if (bus.dma_size != '0) begin
                        start_pkt = 1'b1;
                        state_d   = S_READ;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end

            S_READ: begin
                if ((issued_q < size_q) && (credit_used < CREDITS)) begin
                    rd_en_c = 1'b1;
                    if (issued_q + CW'(1) == size_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (out_fire && head_eop) begin
                    pkt_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, command and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            size_q       <= '0;
            queue_q      <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= zero_done | pkt_done;

            if (start_pkt) begin
                base_q     <= bus.dma_base_addr;
                size_q     <= {1'b0, bus.dma_size};
                queue_q    <= bus.dma_queue;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (rd_en_c) begin
                    issued_q <= issued_q + CW'(1);
                end
                if (rd_accept) begin
                    accepted_q <= accepted_q + CW'(1);
                end
            end

            case ({rd_en_c, rd_accept})
                2'b10:   inflight_q <= inflight_q + FCW'(1);
                2'b01:   inflight_q <= inflight_q - FCW'(1);
                default: inflight_q <= inflight_q;
            endcase

            case ({rd_accept, out_fire})
                2'b10:   fifo_count_q <= fifo_count_q + FCW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - FCW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase

            if (rd_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (out_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            fifo_data[wr_ptr_q]  <= bus.rd_data;
            fifo_sop[wr_ptr_q]   <= flit_sop;
            fifo_eop[wr_ptr_q]   <= flit_eop;
            fifo_queue[wr_ptr_q] <= queue_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.dma_done  = done_q;
        bus.rd_en     = rd_en_c;
        bus.rd_addr   = rd_addr_c;
        bus.out_valid = out_valid_c;
        bus.out_data  = '0;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_queue = '0;
        // the head entry cannot change until it is popped, which keeps the
        // stream stable while stalled
        if (out_valid_c) begin
            bus.out_data  = fifo_data[rd_ptr_q];
            bus.out_sop   = fifo_sop[rd_ptr_q];
            bus.out_eop   = fifo_eop[rd_ptr_q];
            bus.out_queue = fifo_queue[rd_ptr_q];
        end
        busy = (state_q != S_IDLE);
    end

`ifdef PDU_DMA_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
            stat_stall <= '0;
        end else begin
            if (done_q) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (out_fire) begin
                stat_flits <= stat_flits + 32'd1;
            end
            if (out_valid_c && !bus.out_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pdu_dma_reader.sv
// ---------------------------------------------------------------------------
// tb_pdu_dma_reader
//
// Ring buffer model with a 2-cycle read pipeline, directed tests (reset,
// single packet, backpressure, wrap, zero size, back-to-back, reset
// mid-packet) followed by randomized packets with random backpressure.
// Expected flits are derived from the ring contents and the command and
// queued in a scoreboard; a negedge monitor pops and compares every
// output handshake.
// ---------------------------------------------------------------------------
module tb_pdu_dma_reader;

    localparam int AW   = 9;
    localparam int QW   = 4;
    localparam int DW   = 512;
    localparam int FD   = 4;
    localparam int RING = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [QW-1:0] q;
    } flit_t;

    typedef struct packed {
        int c;
        int a;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef PDU_DMA_READER_STATS_EN
    logic [31:0] stat_pkts, stat_flits, stat_stall;
`endif

    pdu_dma_reader_if #(.PDU_AWIDTH(AW), .APP_IDX_WIDTH(QW), .DATA_WIDTH(DW)) bus ();

    pdu_dma_reader #(
        .PDU_DEPTH    (RING),
        .PDU_AWIDTH   (AW),
        .APP_IDX_WIDTH(QW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
`ifdef PDU_DMA_READER_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_flits(stat_flits),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // ---------------- ring buffer model ----------------
    logic [DW-1:0] ring [RING];
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [AW-1:0] p1_a = '0, p2_a = '0;

    always @(posedge clk) begin
        p1_v <= bus.rd_en;
        p1_a <= bus.rd_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    assign bus.rd_valid = p2_v;
    assign bus.rd_data  = p2_v ? ring[p2_a] : '0;

    // ---------------- downstream ready ----------------
    int mode = 0;   // 0: always ready, 1: toggle, 2: random
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    flit_t sb[$];
    rd_t   rd_log[$];
    int    done_log[$];
    int    outstanding = 0;
    int    max_out = 0;
    logic  prev_stall = 1'b0;
    flit_t held;
    int    tot_pkts = 0, tot_flits = 0, tot_stall = 0;

    always @(negedge clk) begin
        flit_t cur, exp;
        if (rst) begin
            prev_stall  = 1'b0;
            outstanding = 0;
            tot_pkts    = 0;
            tot_flits   = 0;
            tot_stall   = 0;
        end else begin
            cur = '{data: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, q: bus.out_queue};
            if (bus.rd_en) begin
                rd_log.push_back('{c: cyc, a: int'(bus.rd_addr)});
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (bus.dma_done) begin
                done_log.push_back(cyc);
                tot_pkts++;
            end
            if (prev_stall) begin
                check("hold_stable", bus.out_valid && (cur == held),
                      $sformatf("valid=%0b sop=%0b eop=%0b q=%0d, required held sop=%0b eop=%0b q=%0d",
                                bus.out_valid, cur.sop, cur.eop, cur.q, held.sop, held.eop, held.q));
            end
            if (bus.out_valid && bus.out_ready) begin
                outstanding--;
                tot_flits++;
                check("flit_expected", sb.size() != 0,
                      $sformatf("got flit q=%0d sop=%0b eop=%0b, required no flit", cur.q, cur.sop, cur.eop));
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("flit", cur == exp,
                          $sformatf("got sop=%0b eop=%0b q=%0d data=%h, required sop=%0b eop=%0b q=%0d data=%h",
                                    cur.sop, cur.eop, cur.q, cur.data, exp.sop, exp.eop, exp.q, exp.data));
                end
            end
            if (bus.out_valid && !bus.out_ready) tot_stall++;
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = cur;
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input int base, input int size, input int q, output int t);
        flit_t f;
        bus.dma_start     = 1'b1;
        bus.dma_base_addr = AW'(base);
        bus.dma_size      = AW'(size);
        bus.dma_queue     = QW'(q);
        t = cyc;
        for (int i = 0; i < size; i++) begin
            f.data = ring[(base + i) % RING];
            f.sop  = (i == 0);
            f.eop  = (i == size - 1);
            f.q    = QW'(q);
            sb.push_back(f);
        end
        @(posedge clk);
        #1;
        bus.dma_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        int n = 0;
        dc = -1;
        while (done_log.size() == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dma_done_seen", done_log.size() != 0,
              $sformatf("no dma_done within %0d cycles, required one", budget));
        if (done_log.size() != 0) dc = done_log.pop_front();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, t2, d, n, base, size, q;

        for (int i = 0; i < RING; i++)
            for (int w = 0; w < DW / 32; w++)
                ring[i][w*32 +: 32] = $urandom;

        bus.dma_start     = 1'b0;
        bus.dma_size      = '0;
        bus.dma_base_addr = '0;
        bus.dma_queue     = '0;
        rst = 1'b1;
        idle(3);

        // reset values
        check("rst_dma_done",  bus.dma_done == 1'b0,  $sformatf("got %0b, required 0", bus.dma_done));
        check("rst_rd_en",     bus.rd_en == 1'b0,     $sformatf("got %0b, required 0", bus.rd_en));
        check("rst_rd_addr",   bus.rd_addr == '0,     $sformatf("got %0d, required 0", bus.rd_addr));
        check("rst_out_valid", bus.out_valid == 1'b0, $sformatf("got %0b, required 0", bus.out_valid));
        check("rst_out_sop",   bus.out_sop == 1'b0,   $sformatf("got %0b, required 0", bus.out_sop));
        check("rst_out_eop",   bus.out_eop == 1'b0,   $sformatf("got %0b, required 0", bus.out_eop));
        check("rst_out_queue", bus.out_queue == '0,   $sformatf("got %0d, required 0", bus.out_queue));
        check("rst_out_data",  bus.out_data == '0,    "got nonzero data, required 0");
        check("rst_busy",      busy == 1'b0,          $sformatf("got %0b, required 0", busy));
        rst = 1'b0;
        idle(2);

        // single packet: base 0, size 4, queue 3
        mode = 0;
        rd_log.delete();
        send_cmd(0, 4, 3, t);
        check("single_busy", busy == 1'b1, $sformatf("got %0b, required 1", busy));
        wait_done(60, d);
        check("single_done_time", d == t + 8, $sformatf("got T+%0d, required T+8", d - t));
        check("single_rd_count", rd_log.size() == 4, $sformatf("got %0d reads, required 4", rd_log.size()));
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            check("single_rd", rd_log[i].c == t + 1 + i && rd_log[i].a == i,
                  $sformatf("read %0d at T+%0d addr %0d, required T+%0d addr %0d",
                            i, rd_log[i].c - t, rd_log[i].a, 1 + i, i));
        idle(2);

        // backpressure: toggling ready
        mode = 1;
        rd_log.delete();
        max_out = 0;
        send_cmd(100, 8, 5, t);
        wait_done(200, d);
        check("bp_all_delivered", sb.size() == 0, $sformatf("%0d flits left, required 0", sb.size()));
        check("bp_reads", rd_log.size() == 8, $sformatf("got %0d reads, required 8", rd_log.size()));
        check("bp_credit", max_out <= FD, $sformatf("got %0d outstanding, required <= %0d", max_out, FD));
        mode = 0;
        idle(3);

        // wrap around the ring end
        rd_log.delete();
        send_cmd(510, 4, 7, t);
        wait_done(60, d);
        check("wrap_done_time", d == t + 8, $sformatf("got T+%0d, required T+8", d - t));
        check("wrap_rd_count", rd_log.size() == 4, $sformatf("got %0d reads, required 4", rd_log.size()));
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            check("wrap_rd_addr", rd_log[i].a == (510 + i) % RING,
                  $sformatf("read %0d addr %0d, required %0d", i, rd_log[i].a, (510 + i) % RING));
        idle(2);

        // zero size
        rd_log.delete();
        send_cmd(33, 0, 2, t);
        wait_done(20, d);
        check("zero_done_time", d == t + 1, $sformatf("got T+%0d, required T+1", d - t));
        idle(4);
        check("zero_no_reads", rd_log.size() == 0, $sformatf("got %0d reads, required 0", rd_log.size()));
        check("zero_single_pulse", done_log.size() == 0, $sformatf("got %0d extra pulses, required 0", done_log.size()));

        // back-to-back: second command right after the first dma_done
        rd_log.delete();
        send_cmd(200, 2, 1, t);
        wait_done(40, d);
        check("b2b_done1_time", d == t + 6, $sformatf("got T+%0d, required T+6", d - t));
        send_cmd(202, 2, 2, t2);
        check("b2b_start_time", t2 == d + 1, $sformatf("second start at done+%0d, required done+1", t2 - d));
        wait_done(40, d);
        check("b2b_done2_time", d == t2 + 6, $sformatf("got T+%0d, required T+6", d - t2));
        check("b2b_rd_count", rd_log.size() == 4, $sformatf("got %0d reads, required 4", rd_log.size()));
        if (rd_log.size() == 4)
            check("b2b_second_rd", rd_log[2].c == t2 + 1 && rd_log[2].a == 202,
                  $sformatf("got T+%0d addr %0d, required T+1 addr 202", rd_log[2].c - t2, rd_log[2].a));
        idle(2);

        // reset mid-packet after three reads
        rd_log.delete();
        send_cmd(300, 6, 4, t);
        n = 0;
        while (rd_log.size() < 3 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midrst_reads_reached", rd_log.size() == 3, $sformatf("got %0d reads, required 3", rd_log.size()));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", bus.out_valid == 1'b0, $sformatf("got %0b, required 0", bus.out_valid));
        check("midrst_rd_en",     bus.rd_en == 1'b0,     $sformatf("got %0b, required 0", bus.rd_en));
        check("midrst_rd_addr",   bus.rd_addr == '0,     $sformatf("got %0d, required 0", bus.rd_addr));
        check("midrst_busy",      busy == 1'b0,          $sformatf("got %0b, required 0", busy));
        rst = 1'b0;
        rd_log.delete();
        done_log.delete();
        idle(6);
        check("midrst_no_done",  done_log.size() == 0, $sformatf("got %0d pulses, required 0", done_log.size()));
        check("midrst_no_reads", rd_log.size() == 0,   $sformatf("got %0d reads, required 0", rd_log.size()));
        send_cmd(40, 2, 6, t);
        wait_done(40, d);
        check("midrst_next_done", d == t + 6, $sformatf("got T+%0d, required T+6", d - t));
        idle(2);

        // randomized packets with random backpressure
        mode = 2;
        for (int k = 0; k < 24; k++) begin
            base = $urandom_range(0, RING - 1);
            size = $urandom_range(0, 24);
            q    = $urandom_range(0, (1 << QW) - 1);
            send_cmd(base, size, q, t);
            wait_done(40 + size * 10, d);
            check("rand_drained", sb.size() == 0, $sformatf("%0d flits left, required 0", sb.size()));
            if (size == 0)
                check("rand_zero_done", d == t + 1, $sformatf("got T+%0d, required T+1", d - t));
            idle($urandom_range(0, 3));
        end
        mode = 0;
        idle(4);

`ifdef PDU_DMA_READER_STATS_EN
        check("stat_pkts",  stat_pkts == 32'(tot_pkts),   $sformatf("got %0d, required %0d", stat_pkts, tot_pkts));
        check("stat_flits", stat_flits == 32'(tot_flits), $sformatf("got %0d, required %0d", stat_flits, tot_flits));
        check("stat_stall", stat_stall == 32'(tot_stall), $sformatf("got %0d, required %0d", stat_stall, tot_stall));
`endif

        check("final_sb_empty", sb.size() == 0, $sformatf("%0d flits left, required 0", sb.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

endmodule
